// File: rtl/leb128_decoder.sv
// leb128_decoder: streaming ULEB128/SLEB128 immediate decoder for the fetch path.
// Accepts encoded bytes after start, delivers the zero/sign-extended value, the byte
// count and an error code to the execute stage; malformed encodings report an error.
//
// Build option: define LEB128_STRICT_EN to enable the unused-high-bit check on the last
// permitted byte (reports OVERFLOW); otherwise excess bits are silently truncated.
//
// Ports:
//   clk, reset    clock; asynchronous active-low reset
//   start         begin decode (sampled only in IDLE); latches is_signed / is_64
//   in_data/in_valid/in_ready    encoded byte stream, accepted on valid & ready
//   out_value/out_len/out_error  result, byte count, error (0 none, 1 TOO_LONG, 2 OVERFLOW)
//   out_valid/out_ready          result handshake, held until accepted
//   busy          high in any state other than IDLE
module leb128_decoder #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MAX_BYTES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             is_64,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [3:0]       out_len,
  output logic [1:0]       out_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned LIM32 = 5;
  localparam logic [1:0]  ERR_NONE     = 2'd0;
  localparam logic [1:0]  ERR_TOO_LONG = 2'd1;
  localparam logic [1:0]  ERR_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [3:0]       count, count_n;
  logic             sgn, sgn_n;
  logic             w64, w64_n;
  logic             in_ready_n, out_valid_n, busy_n;
  logic [WIDTH-1:0] out_value_n;
  logic [3:0]       out_len_n;
  logic [1:0]       out_error_n;

  // Datapath helpers for the byte currently offered
  logic [6:0]       sh, sh_n, wbits;
  logic [3:0]       cnt_inc, lim;
  logic [WIDTH-1:0] grp, acc_or, ext_mask, val_c;
  logic             ovf_c;

  always_comb begin
    sh       = 7'd7 * 7'(count);
    sh_n     = sh + 7'd7;
    wbits    = w64 ? 7'd64 : 7'd32;
    cnt_inc  = count + 4'd1;
    lim      = w64 ? 4'(MAX_BYTES) : 4'(LIM32);
    grp      = WIDTH'(in_data[6:0]) << sh;
    acc_or   = acc | grp;
    ext_mask = ~WIDTH'(0) << sh_n;
    val_c    = acc_or;
    // Sign-extend from the terminal byte when bits remain above it
    if (sgn && in_data[6] && (sh_n < wbits)) begin
      val_c = acc_or | ext_mask;
    end
    // 32-bit results never carry anything above bit 31
    if (!w64) begin
      val_c = val_c & WIDTH'(64'h0000_0000_FFFF_FFFF);
    end
  end

`ifdef LEB128_STRICT_EN
  // Unused high bits of the last permitted byte must be zero (or pure sign copies)
  always_comb begin
    unique case ({w64, sgn})
      2'b00:   ovf_c = (in_data[6:4] != 3'b000);
      2'b01:   ovf_c = (in_data[6:3] != 4'b0000) && (in_data[6:3] != 4'b1111);
      2'b10:   ovf_c = (in_data[6:1] != 6'b000000);
      default: ovf_c = (in_data[6:0] != 7'h00) && (in_data[6:0] != 7'h7F);
    endcase
  end
`else
  always_comb ovf_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    count_n     = count;
    sgn_n       = sgn;
    w64_n       = w64;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    busy_n      = busy;
    out_value_n = out_value;
    out_len_n   = out_len;
    out_error_n = out_error;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = ACCUM;
          acc_n      = '0;
          count_n    = '0;
          sgn_n      = is_signed;
          w64_n      = is_64;
          in_ready_n = 1'b1;
          busy_n     = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid && in_ready) begin
          acc_n   = acc_or;
          count_n = cnt_inc;
          if ((cnt_inc == lim) && (in_data[7] || ovf_c)) begin
            state_n     = DONE;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
            out_value_n = '0;
            out_len_n   = cnt_inc;
            out_error_n = in_data[7] ? ERR_TOO_LONG : ERR_OVERFLOW;
          end else if (!in_data[7]) begin
            state_n     = DONE;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
            out_value_n = val_c;
            out_len_n   = cnt_inc;
            out_error_n = ERR_NONE;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          busy_n      = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        in_ready_n  = 1'b0;
        out_valid_n = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      sgn       <= 1'b0;
      w64       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_value <= '0;
      out_len   <= '0;
      out_error <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      count     <= count_n;
      sgn       <= sgn_n;
      w64       <= w64_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      out_value <= out_value_n;
      out_len   <= out_len_n;
      out_error <= out_error_n;
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// tb_leb128_decoder: directed self-checking bench for leb128_decoder.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_leb128_decoder;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_signed, is_64;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic [1:0]  out_error;
  logic        out_valid, out_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;

  leb128_decoder #(.WIDTH(64), .MAX_BYTES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .is_64(is_64),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_len(out_len), .out_error(out_error),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // All tasks are entered just after a falling edge
  task automatic start_dec(input logic s, input logic w);
    start = 1'b1; is_signed = s; is_64 = w;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic get_result(input string tag, input logic [63:0] ev,
                            input logic [3:0] el, input logic [1:0] ee);
    wait_valid(tag);
    check({tag, "_value"}, out_value, ev);
    check({tag, "_len"}, 64'(out_len), 64'(el));
    check({tag, "_error"}, 64'(out_error), 64'(ee));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run(input string tag, input logic s, input logic w, input bq_t q,
                     input logic [63:0] ev, input logic [3:0] el, input logic [1:0] ee);
    start_dec(s, w);
    foreach (q[i]) send_byte(tag, q[i]);
    get_result(tag, ev, el, ee);
  endtask

  bq_t q;

  initial begin
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; is_64 = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_len", 64'(out_len), 64'd0);
    check("rst_out_error", 64'(out_error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: ULEB32 E5 8E 26 = 0x98765
    q = {8'hE5, 8'h8E, 8'h26};
    run("uleb32", 1'b0, 1'b0, q, 64'h0000_0000_0009_8765, 4'd3, 2'd0);

    // 2: SLEB32 7F, byte presented in the start cycle, result two cycles after start
    start = 1'b1; is_signed = 1'b1; is_64 = 1'b0;
    in_data = 8'h7F; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sleb32_lat_early", 64'(out_valid), 64'd0);
    check("sleb32_lat_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("sleb32_lat_valid", 64'(out_valid), 64'd1);
    get_result("sleb32", 64'h0000_0000_FFFF_FFFF, 4'd1, 2'd0);

    // 3: SLEB64 C0 BB 78 = -123456 (start right after the previous handshake)
    q = {8'hC0, 8'hBB, 8'h78};
    run("sleb64", 1'b1, 1'b1, q, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0);

    // SLEB32 minimum: 80 80 80 80 78 = 0x8000_0000, upper half zero
    q = {8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
    run("sleb32_min", 1'b1, 1'b0, q, 64'h0000_0000_8000_0000, 4'd5, 2'd0);

    // ULEB64 at the 10-byte limit: all ones
    q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    run("uleb64_max", 1'b0, 1'b1, q, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0);

    // 4: ULEB32 too long; a sixth byte is offered but must not be taken
    start_dec(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte("toolong", 8'hFF);
    in_data = 8'h01; in_valid = 1'b1;
    check("toolong_no_take0", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("toolong_no_take1", 64'(in_ready), 64'd0);
    get_result("toolong", 64'd0, 4'd5, 2'd1);
    check("toolong_idle_no_take", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);

    // 5: ULEB32 with excess bits in byte 5
    q = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
`ifdef LEB128_STRICT_EN
    run("excess32", 1'b0, 1'b0, q, 64'd0, 4'd5, 2'd2);
`else
    run("excess32", 1'b0, 1'b0, q, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0);
`endif

    // 6a: backpressure holds ULEB64 80 01 = 128
    start_dec(1'b0, 1'b1);
    send_byte("bp", 8'h80);
    send_byte("bp", 8'h01);
    wait_valid("bp_pre");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_value", out_value, 64'd128);
      check("bp_hold_len", 64'(out_len), 64'd2);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    get_result("bp", 64'd128, 4'd2, 2'd0);

    // 6b: reset in the middle of a decode, then a clean decode of 05
    start_dec(1'b0, 1'b0);
    send_byte("midrst", 8'h80);
    send_byte("midrst", 8'h80);
    check("midrst_busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    q = {8'h05};
    run("after_rst", 1'b0, 1'b0, q, 64'd5, 4'd1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
